// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS-subset pipeline.
// Contents: width defaults, opcode/funct constants, the decoded-control struct
// and the decode helper used by the ID stage.
package cpu_pkg;

  localparam int unsigned XLEN_DEFAULT  = 32;
  localparam int unsigned RADDR_DEFAULT = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [5:0] FN_JR = 6'h08;

  typedef struct packed {
    logic [4:0] dst;
    logic       use_s;     // rs is a real source operand
    logic       use_t;     // rt is a real source operand
    logic       zero_ext;  // logical immediates are zero-extended
    logic       reg_write;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       illegal;
  } ctrl_t;

  function automatic ctrl_t decode(input logic [31:0] instr);
    ctrl_t c;
    c = '0;
    case (instr[31:26])
      OP_RTYPE: begin
        c.dst       = instr[15:11];
        c.use_s     = 1'b1;
        c.use_t     = 1'b1;
        c.reg_write = (instr[5:0] != FN_JR);
      end
      OP_LW: begin
        c.dst       = instr[20:16];
        c.use_s     = 1'b1;
        c.reg_write = 1'b1;
        c.is_load   = 1'b1;
      end
      OP_SW: begin
        c.use_s    = 1'b1;
        c.use_t    = 1'b1;
        c.is_store = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        c.use_s     = 1'b1;
        c.use_t     = 1'b1;
        c.is_branch = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI: begin
        c.dst       = instr[20:16];
        c.use_s     = 1'b1;
        c.reg_write = 1'b1;
      end
      OP_LUI: begin
        c.dst       = instr[20:16];
        c.reg_write = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        c.dst       = instr[20:16];
        c.use_s     = 1'b1;
        c.reg_write = 1'b1;
        c.zero_ext  = 1'b1;
      end
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// Operand select for one source register of the ID stage.
// Inputs: source address and whether it is used, EX/MEM/WB producer info,
// register-file read data. Output: val, the forwarded operand (0 for $0 or
// when the source is not used by the instruction).
module id_fwd_mux
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned RADDR = RADDR_DEFAULT
) (
  input  logic             used,
  input  logic [RADDR-1:0] src,
  input  logic             ex_valid,
  input  logic             ex_reg_write,
  input  logic             ex_is_load,
  input  logic [RADDR-1:0] ex_dst,
  input  logic [XLEN-1:0]  ex_alu_result,
  input  logic             mem_wr,
  input  logic [RADDR-1:0] mem_dst,
  input  logic [XLEN-1:0]  mem_result,
  input  logic             wb_wr,
  input  logic [RADDR-1:0] wb_dst,
  input  logic [XLEN-1:0]  wb_data,
  input  logic [XLEN-1:0]  rf_data,
  output logic [XLEN-1:0]  val
);

  // Youngest producer wins; a load in EX has no value yet (stall covers it).
  always_comb begin
    val = rf_data;
    if (!used || src == '0) begin
      val = '0;
    end else if (ex_valid && ex_reg_write && !ex_is_load && ex_dst == src) begin
      val = ex_alu_result;
    end else if (mem_wr && mem_dst == src) begin
      val = mem_result;
    end else if (wb_wr && wb_dst == src) begin
      val = wb_data;
    end
  end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: IF/ID register, decode, operand forwarding,
// load-use stall detection and the ID/EX register.
// Ports: fetch handshake (if_*, id_stall), flush from EX, register-file
// read port (rf_*), producer info from EX/MEM/WB, ID/EX outputs (ex_*).
module id_stage
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned RADDR = RADDR_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_valid,
  input  logic [XLEN-1:0]  if_instr,
  input  logic [XLEN-1:0]  if_pc,
  output logic             id_stall,
  input  logic             flush,
  output logic [RADDR-1:0] rf_s_addr,
  output logic [RADDR-1:0] rf_t_addr,
  input  logic [XLEN-1:0]  rf_s_data,
  input  logic [XLEN-1:0]  rf_t_data,
  input  logic [XLEN-1:0]  ex_alu_result,
  input  logic             mem_wr,
  input  logic [RADDR-1:0] mem_dst,
  input  logic [XLEN-1:0]  mem_result,
  input  logic             wb_wr,
  input  logic [RADDR-1:0] wb_dst,
  input  logic [XLEN-1:0]  wb_data,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [5:0]       ex_opcode,
  output logic [5:0]       ex_funct,
  output logic [4:0]       ex_shamt,
  output logic [XLEN-1:0]  ex_imm,
  output logic [XLEN-1:0]  ex_s_val,
  output logic [XLEN-1:0]  ex_t_val,
  output logic [RADDR-1:0] ex_dst,
  output logic             ex_reg_write,
  output logic             ex_is_load,
  output logic             ex_is_store,
  output logic             ex_is_branch,
  output logic             ex_illegal
);

  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  pc;
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic [4:0]       shamt;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  s_val;
    logic [XLEN-1:0]  t_val;
    logic [RADDR-1:0] dst;
    logic             reg_write;
    logic             is_load;
    logic             is_store;
    logic             is_branch;
    logic             illegal;
  } idex_t;

  logic            ifid_valid_q;
  logic [XLEN-1:0] ifid_instr_q;
  logic [XLEN-1:0] ifid_pc_q;
  idex_t           idex_d, idex_q;
  ctrl_t           ctrl;
  logic [15:0]     imm16;
  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] s_val, t_val;

  // IF/ID register: flush kills the fetched instruction, stall holds it.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= '0;
      ifid_pc_q    <= '0;
    end else if (!id_stall) begin
      ifid_valid_q <= if_valid;
      ifid_instr_q <= if_instr;
      ifid_pc_q    <= if_pc;
    end
  end

  assign ctrl      = decode(ifid_instr_q[31:0]);
  assign rf_s_addr = ifid_instr_q[25:21];
  assign rf_t_addr = ifid_instr_q[20:16];
  assign imm16     = ifid_instr_q[15:0];
  assign imm_ext   = ctrl.zero_ext ? {{(XLEN-16){1'b0}}, imm16}
                                   : {{(XLEN-16){imm16[15]}}, imm16};

  // A load in EX cannot forward yet; hold one cycle until it reaches MEM.
  assign id_stall = ifid_valid_q && idex_q.valid && idex_q.is_load && (idex_q.dst != '0) &&
                    ((ctrl.use_s && idex_q.dst == rf_s_addr) ||
                     (ctrl.use_t && idex_q.dst == rf_t_addr));

  id_fwd_mux #(.XLEN(XLEN), .RADDR(RADDR)) u_fwd_s (
    .used          (ctrl.use_s),
    .src           (rf_s_addr),
    .ex_valid      (idex_q.valid),
    .ex_reg_write  (idex_q.reg_write),
    .ex_is_load    (idex_q.is_load),
    .ex_dst        (idex_q.dst),
    .ex_alu_result (ex_alu_result),
    .mem_wr        (mem_wr),
    .mem_dst       (mem_dst),
    .mem_result    (mem_result),
    .wb_wr         (wb_wr),
    .wb_dst        (wb_dst),
    .wb_data       (wb_data),
    .rf_data       (rf_s_data),
    .val           (s_val)
  );

  id_fwd_mux #(.XLEN(XLEN), .RADDR(RADDR)) u_fwd_t (
    .used          (ctrl.use_t),
    .src           (rf_t_addr),
    .ex_valid      (idex_q.valid),
    .ex_reg_write  (idex_q.reg_write),
    .ex_is_load    (idex_q.is_load),
    .ex_dst        (idex_q.dst),
    .ex_alu_result (ex_alu_result),
    .mem_wr        (mem_wr),
    .mem_dst       (mem_dst),
    .mem_result    (mem_result),
    .wb_wr         (wb_wr),
    .wb_dst        (wb_dst),
    .wb_data       (wb_data),
    .rf_data       (rf_t_data),
    .val           (t_val)
  );

  // Bubble (all zero) on flush, stall or empty IF/ID.
  always_comb begin
    idex_d = '0;
    if (ifid_valid_q && !id_stall && !flush) begin
      idex_d.valid     = 1'b1;
      idex_d.pc        = ifid_pc_q;
      idex_d.opcode    = ifid_instr_q[31:26];
      idex_d.funct     = ifid_instr_q[5:0];
      idex_d.shamt     = ifid_instr_q[10:6];
      idex_d.imm       = imm_ext;
      idex_d.s_val     = s_val;
      idex_d.t_val     = t_val;
      idex_d.dst       = ctrl.dst;
      idex_d.reg_write = ctrl.reg_write;
      idex_d.is_load   = ctrl.is_load;
      idex_d.is_store  = ctrl.is_store;
      idex_d.is_branch = ctrl.is_branch;
      idex_d.illegal   = ctrl.illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign ex_valid     = idex_q.valid;
  assign ex_pc        = idex_q.pc;
  assign ex_opcode    = idex_q.opcode;
  assign ex_funct     = idex_q.funct;
  assign ex_shamt     = idex_q.shamt;
  assign ex_imm       = idex_q.imm;
  assign ex_s_val     = idex_q.s_val;
  assign ex_t_val     = idex_q.t_val;
  assign ex_dst       = idex_q.dst;
  assign ex_reg_write = idex_q.reg_write;
  assign ex_is_load   = idex_q.is_load;
  assign ex_is_store  = idex_q.is_store;
  assign ex_is_branch = idex_q.is_branch;
  assign ex_illegal   = idex_q.illegal;

endmodule
